// File: rtl/band_pkg.sv
// Shared definitions for the band level register bank: CTRL bit positions,
// register address offsets and the write-data clamp helper.
package band_pkg;

  localparam int unsigned CTRL_SYNC_BIT = 0;
  localparam int unsigned CTRL_RAMP_BIT = 1;
  localparam int unsigned CTRL_W        = 2;

  // CTRL and STATUS sit directly above the per-band registers.
  function automatic int unsigned ctrl_addr(input int unsigned num_bands);
    return num_bands;
  endfunction

  function automatic int unsigned status_addr(input int unsigned num_bands);
    return num_bands + 1;
  endfunction

  // Saturate to the largest representable level instead of dropping high bits.
  function automatic logic [15:0] clamp_level(input logic [15:0] data,
                                              input int unsigned level_w);
    logic [15:0] max_level;
    max_level = 16'((32'd1 << level_w) - 32'd1);
    return (data > max_level) ? max_level : data;
  endfunction

endpackage

// File: rtl/band_level_bank_ramp_cell.sv
// One band's committed shadow target and displayed level, with the per-frame
// step that walks the displayed level toward the shadow.
module band_ramp_cell #(
  parameter int unsigned LEVEL_W       = 5,
  parameter int unsigned DEFAULT_LEVEL = 16,
  parameter int unsigned RAMP_STEP     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start_i,
  input  logic               commit_i,
  input  logic [LEVEL_W-1:0] commit_level_i,
  input  logic               ramp_en_i,
  output logic [LEVEL_W-1:0] shadow_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam logic [LEVEL_W-1:0] DEFAULT_L = LEVEL_W'(DEFAULT_LEVEL);
  localparam logic [LEVEL_W:0]   STEP_W    = (LEVEL_W + 1)'(RAMP_STEP);

  logic [LEVEL_W-1:0] shadow_q, shadow_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W:0]   wide_s, wide_l, diff;

  always_comb begin
    shadow_d = shadow_q;
    level_d  = level_q;
    wide_s   = '0;
    wide_l   = '0;
    diff     = '0;

    if (commit_i) shadow_d = commit_level_i;

    // The ramp chases the shadow value being written on this same edge.
    if (frame_start_i) begin
      if (!ramp_en_i || RAMP_STEP == 0) begin
        level_d = shadow_d;
      end else begin
        wide_s = {1'b0, shadow_d};
        wide_l = {1'b0, level_q};
        diff   = (wide_s >= wide_l) ? (wide_s - wide_l) : (wide_l - wide_s);
        if (32'(diff) <= RAMP_STEP) level_d = shadow_d;
        else if (wide_s > wide_l)   level_d = LEVEL_W'(wide_l + STEP_W);
        else                        level_d = LEVEL_W'(wide_l - STEP_W);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain shadow into level in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= DEFAULT_L;
      level_q  <= DEFAULT_L;
    end else begin
      shadow_q <= shadow_d;
      level_q  <= level_d;
    end
  end

  assign shadow_o = shadow_q;
  assign level_o  = level_q;

endmodule

// File: rtl/band_level_bank.sv
// Avalon-MM register bank for equalizer band levels: pending targets, frame
// synchronised commit into per-band shadows, and ramped displayed levels.
module band_level_bank
  import band_pkg::*;
#(
  parameter int unsigned NUM_BANDS     = 12,
  parameter int unsigned LEVEL_W       = 5,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned DEFAULT_LEVEL = 16,
  parameter int unsigned RAMP_STEP     = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           chipselect,
  input  logic                           write,
  input  logic                           read,
  input  logic [ADDR_W-1:0]              address,
  input  logic [15:0]                    writedata,
  output logic [15:0]                    readdata,
  input  logic                           frame_start,
  output logic [NUM_BANDS*LEVEL_W-1:0]   level_out,
  output logic [NUM_BANDS*LEVEL_W-1:0]   target_out,
  output logic                           busy
);

  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t            DEFAULT_L   = level_t'(DEFAULT_LEVEL);
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_addr(NUM_BANDS));
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(NUM_BANDS));

  level_t              pending_q [NUM_BANDS];
  level_t              pending_d [NUM_BANDS];
  level_t              shadow_w  [NUM_BANDS];
  level_t              level_w   [NUM_BANDS];
  logic [NUM_BANDS-1:0] busy_vec;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]         readdata_q, readdata_d;

  logic   wr_en, rd_en, band_wr, sync_mode, ramp_en;
  level_t wr_level;

  assign wr_en     = chipselect && write;
  assign rd_en     = chipselect && read;
  assign band_wr   = wr_en && (32'(address) < NUM_BANDS);
  assign wr_level  = level_t'(clamp_level(writedata, LEVEL_W));
  assign sync_mode = ctrl_q[CTRL_SYNC_BIT];
  assign ramp_en   = ctrl_q[CTRL_RAMP_BIT];

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so a
    // path that skips an assignment holds nothing and no latch is inferred.
    pending_d   = pending_q;
    ctrl_d      = ctrl_q;
    frame_cnt_d = frame_cnt_q;
    readdata_d  = readdata_q;

    if (band_wr) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (address == ADDR_W'(i)) pending_d[i] = wr_level;
      end
    end
    if (wr_en && address == CTRL_ADDR) ctrl_d = writedata[CTRL_W-1:0];
    if (frame_start) frame_cnt_d = frame_cnt_q + 8'd1;

    if (rd_en) begin
      readdata_d = '0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (address == ADDR_W'(i)) readdata_d = 16'(pending_q[i]);
      end
      if (address == CTRL_ADDR)   readdata_d = 16'(ctrl_q);
      if (address == STATUS_ADDR) readdata_d = {7'b0, busy, frame_cnt_q};
    end
  end

  // NOTE: the pending array is only NUM_BANDS small registers and must come up
  // at DEFAULT_LEVEL, so it is reset like any other flop rather than left as RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANDS; i++) pending_q[i] <= DEFAULT_L;
      ctrl_q      <= 2'b11;
      frame_cnt_q <= '0;
      readdata_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      ctrl_q      <= ctrl_d;
      frame_cnt_q <= frame_cnt_d;
      readdata_q  <= readdata_d;
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    logic   commit;
    level_t commit_level;

    // Sync mode commits the pre-write pending value on frame_start; immediate
    // mode commits the clamped write data alongside the pending update.
    assign commit       = sync_mode ? frame_start : (band_wr && address == ADDR_W'(g));
    assign commit_level = sync_mode ? pending_q[g] : wr_level;

    band_ramp_cell #(
      .LEVEL_W      (LEVEL_W),
      .DEFAULT_LEVEL(DEFAULT_LEVEL),
      .RAMP_STEP    (RAMP_STEP)
    ) u_cell (
      .clk           (clk),
      .reset_n       (reset_n),
      .frame_start_i (frame_start),
      .commit_i      (commit),
      .commit_level_i(commit_level),
      .ramp_en_i     (ramp_en),
      .shadow_o      (shadow_w[g]),
      .level_o       (level_w[g])
    );

    assign level_out [g*LEVEL_W +: LEVEL_W] = level_w[g];
    assign target_out[g*LEVEL_W +: LEVEL_W] = shadow_w[g];
    assign busy_vec[g] = (level_w[g] != shadow_w[g]);
  end

  assign busy     = |busy_vec;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_band_level_bank.sv
// Self-checking bench for band_level_bank: directed scenarios plus random bus
// traffic, compared against a behavioural model with a read-data scoreboard.
module tb_band_level_bank;

  localparam int NB   = 12;
  localparam int W    = 5;
  localparam int AW   = 6;
  localparam int DEF  = 16;
  localparam int STEP = 4;
  localparam int MAXL = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [AW-1:0]     address = '0;
  logic [15:0]       writedata = '0;
  logic              frame_start = 1'b0;
  logic [15:0]       readdata;
  logic [NB*W-1:0]   level_out;
  logic [NB*W-1:0]   target_out;
  logic              busy;

  band_level_bank #(
    .NUM_BANDS    (NB),
    .LEVEL_W      (W),
    .ADDR_W       (AW),
    .DEFAULT_LEVEL(DEF),
    .RAMP_STEP    (STEP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .frame_start(frame_start),
    .level_out  (level_out),
    .target_out (target_out),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  int m_pend[NB];
  int m_shad[NB];
  int m_lvl[NB];
  int m_ctrl;
  int m_fc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_busy();
    for (int i = 0; i < NB; i++) if (m_lvl[i] != m_shad[i]) return 1;
    return 0;
  endfunction

  function automatic logic [NB*W-1:0] pack(input int v[NB]);
    logic [NB*W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  function automatic int fld(input logic [NB*W-1:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  function automatic logic [15:0] model_read(input int a);
    if (a < NB)      return 16'(m_pend[a]);
    if (a == NB)     return 16'(m_ctrl);
    if (a == NB + 1) return 16'((model_busy() << 8) | m_fc);
    return 16'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_pend[i] = DEF;
      m_shad[i] = DEF;
      m_lvl[i]  = DEF;
    end
    m_ctrl = 3;
    m_fc   = 0;
  endtask

  // One clock edge of the block, written from the register-level rules.
  task automatic model_edge(input bit cs, input bit wr, input int a, input int data, input bit fs);
    bit band_w;
    int val, diff;
    bit sync_m, ramp_m;
    band_w = cs && wr && (a < NB);
    val    = (data > MAXL) ? MAXL : data;
    sync_m = m_ctrl[0];
    ramp_m = m_ctrl[1];
    if (sync_m && fs) for (int i = 0; i < NB; i++) m_shad[i] = m_pend[i];
    if (!sync_m && band_w) m_shad[a] = val;
    if (band_w) m_pend[a] = val;
    if (cs && wr && a == NB) m_ctrl = data & 3;
    if (fs) begin
      m_fc = (m_fc + 1) % 256;
      for (int i = 0; i < NB; i++) begin
        diff = m_shad[i] - m_lvl[i];
        if (!ramp_m || STEP == 0 || (diff <= STEP && diff >= -STEP)) m_lvl[i] = m_shad[i];
        else if (diff > 0) m_lvl[i] = m_lvl[i] + STEP;
        else               m_lvl[i] = m_lvl[i] - STEP;
      end
    end
  endtask

  task automatic check_outputs();
    check("level_out", 64'(level_out), 64'(pack(m_lvl)));
    check("target_out", 64'(target_out), 64'(pack(m_shad)));
    check("busy", 64'(busy), 64'(model_busy()));
  endtask

  // Drive one bus cycle at a falling edge, advance the model at the rising edge.
  task automatic cyc(input bit cs, input bit wr, input bit rd, input int a, input int data, input bit fs);
    chipselect  = cs;
    write       = wr;
    read        = rd;
    address     = AW'(a);
    writedata   = 16'(data);
    frame_start = fs;
    if (cs && rd) exp_q.push_back(model_read(a));
    @(posedge clk);
    model_edge(cs, wr, a, data, fs);
    @(negedge clk);
    chipselect  = 1'b0;
    write       = 1'b0;
    read        = 1'b0;
    frame_start = 1'b0;
    check_outputs();
  endtask

  task automatic wr_reg(input int a, input int data);
    cyc(1'b1, 1'b1, 1'b0, a, data, 1'b0);
  endtask

  task automatic rd_reg(input int a);
    cyc(1'b1, 1'b0, 1'b1, a, 0, 1'b0);
  endtask

  task automatic frame();
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  // Read monitor: every accepted read yields one readdata word a cycle later.
  always @(posedge clk) begin
    if (reset_n && chipselect && read) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL readdata: response 0x%0h with no read outstanding", readdata);
      end else begin
        check("readdata", 64'(readdata), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall_seq[8] = '{27, 23, 19, 15, 11, 7, 3, 2};
    logic [NB*W-1:0] all_def;
    for (int i = 0; i < NB; i++) all_def[i*W +: W] = W'(DEF);

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_readdata", 64'(readdata), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_level", 64'(level_out), 64'(all_def));
    check("reset_busy", 64'(busy), 64'h0);

    for (int i = 0; i < NB; i++) rd_reg(i);
    rd_reg(NB);
    rd_reg(NB + 1);
    rd_reg(40);

    // Clamp and frame-synchronised commit.
    wr_reg(3, 45);
    check("clamp_target_held", 64'(fld(target_out, 3)), 64'(DEF));
    rd_reg(3);
    frame();
    check("clamp_level3", 64'(fld(level_out, 3)), 64'd20);
    check("clamp_busy", 64'(busy), 64'h1);

    // Ramped fall from 31 to 2.
    wr_reg(5, 31);
    repeat (4) frame();
    check("fall_start", 64'(fld(level_out, 5)), 64'd31);
    wr_reg(5, 2);
    for (int k = 0; k < 8; k++) begin
      frame();
      check("fall_level5", 64'(fld(level_out, 5)), 64'(fall_seq[k]));
      check("fall_busy", 64'(busy), 64'(k < 7));
    end

    // Immediate commit with ramping off.
    wr_reg(NB, 0);
    wr_reg(0, 9);
    check("imm_target0", 64'(fld(target_out, 0)), 64'd9);
    frame();
    check("imm_level0", 64'(fld(level_out, 0)), 64'd9);

    // Write coinciding with frame_start in sync mode.
    wr_reg(NB, 1);
    cyc(1'b1, 1'b1, 1'b0, 1, 7, 1'b1);
    check("simul_old_target1", 64'(fld(target_out, 1)), 64'(DEF));
    frame();
    check("simul_new_target1", 64'(fld(target_out, 1)), 64'd7);
    rd_reg(NB + 1);

    // Asynchronous reset in the middle of a ramp.
    wr_reg(NB, 3);
    wr_reg(7, 0);
    frame();
    check("pre_reset_level7", 64'(fld(level_out, 7)), 64'd12);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_level", 64'(level_out), 64'(all_def));
    check("async_target", 64'(target_out), 64'(all_def));
    check("async_busy", 64'(busy), 64'h0);
    check("async_readdata", 64'(readdata), 64'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(NB + 1);
    rd_reg(7);

    // Random bus traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit cs, wr, rd, fs;
      int a, d;
      cs = ($urandom_range(0, 9) < 7);
      wr = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 2) == 0;
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << AW) - 1))
                                       : int'($urandom_range(0, NB + 1));
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                       : int'($urandom_range(0, 40));
      fs = $urandom_range(0, 4) == 0;
      cyc(cs, wr, rd, a, d, fs);
    end

    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("read_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
